// File: rtl/pixel_readout.sv
`default_nettype none
// ============================================================================
// Module   : pixel_readout
// Purpose  : Receiving end of the 2x2 pixel array readout. It watches the
//            read1/read2 phase strobes and samples the pixel buses once they
//            have settled. Each row is queued as two bytes in a small FIFO,
//            and the FIFO streams one byte per beat with valid/ready and an
//            end-of-frame marker on pixel 4.
// Ports    : clk, reset (async, active-high)
//            read1, read2          phase strobes (row 1 / row 2)
//            pixData1..pixData4    8-bit pixel output buses
//            out_data/out_valid/out_ready/out_last  byte stream
//            clear                 sync clear of sticky flags and frame_count
//            overflow, protocol_err  sticky status flags
//            frame_count           completed frames pushed (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module pixel_readout #(
  parameter int SAMPLE_DELAY = 4,
  parameter int DEPTH        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read1,
  input  logic       read2,
  input  logic [7:0] pixData1,
  input  logic [7:0] pixData2,
  input  logic [7:0] pixData3,
  input  logic [7:0] pixData4,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  input  logic       clear,
  output logic       overflow,
  output logic       protocol_err,
  output logic [7:0] frame_count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [3:0]  DLY_END = 4'(SAMPLE_DELAY);
  localparam logic [CW-1:0] ROOM2 = CW'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DLY1   = 3'd1,
    S_CAP1   = 3'd2,
    S_PUSH1B = 3'd3,
    S_ROW1   = 3'd4,
    S_DLY2   = 3'd5,
    S_CAP2   = 3'd6,
    S_PUSH2B = 3'd7
  } state_t;

  state_t          state, state_next;
  logic [3:0]      dly_cnt, dly_cnt_next;
  logic            read1_q, read2_q;
  logic [7:0]      hold_byte;

  // FSM request signals
  logic            push;
  logic [7:0]      push_data;
  logic            push_last;
  logic            hold_load;
  logic [7:0]      hold_in;
  logic            perr_set;
  logic            ovf_set;
  logic            frame_inc;

  // FIFO state
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            pop;
  logic            room_ok;

  logic            rise1, rise2;
  assign rise1 = read1 & ~read1_q;
  assign rise2 = read2 & ~read2_q;

  // A pop in this cycle is deliberately not credited: the check uses the
  // registered count only.
  assign room_ok = (count <= ROOM2);

  // --------------------------------------------------------------------------
  // State register and strobe history
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dly_cnt   <= 4'd0;
      read1_q   <= 1'b0;
      read2_q   <= 1'b0;
      hold_byte <= 8'd0;
    end else begin
      state   <= state_next;
      dly_cnt <= dly_cnt_next;
      read1_q <= read1;
      read2_q <= read2;
      if (hold_load) hold_byte <= hold_in;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and request logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    dly_cnt_next = dly_cnt;
    push         = 1'b0;
    push_data    = 8'd0;
    push_last    = 1'b0;
    hold_load    = 1'b0;
    hold_in      = 8'd0;
    perr_set     = 1'b0;
    ovf_set      = 1'b0;
    frame_inc    = 1'b0;

    if (read1 && read2) begin
      // Overlapping strobes abort whatever is in flight.
      perr_set     = 1'b1;
      state_next   = S_IDLE;
      dly_cnt_next = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise1) begin
            state_next   = S_DLY1;
            dly_cnt_next = 4'd1;
          end else if (rise2) begin
            perr_set = 1'b1;
          end
        end
        S_DLY1: begin
          if (!read1) begin
            perr_set     = 1'b1;
            state_next   = S_IDLE;
            dly_cnt_next = 4'd0;
          end else if (dly_cnt == DLY_END) begin
            state_next   = S_CAP1;
            dly_cnt_next = 4'd0;
          end else begin
            dly_cnt_next = dly_cnt + 4'd1;
          end
        end
        S_CAP1: begin
          // Byte 1 goes straight from the bus; byte 2 is held for next cycle.
          hold_load = 1'b1;
          hold_in   = pixData2;
          if (room_ok) begin
            push       = 1'b1;
            push_data  = pixData1;
            state_next = S_PUSH1B;
          end else begin
            ovf_set    = 1'b1;
            state_next = S_ROW1;
          end
        end
        S_PUSH1B: begin
          push       = 1'b1;
          push_data  = hold_byte;
          state_next = S_ROW1;
        end
        S_ROW1: begin
          if (rise2) begin
            state_next   = S_DLY2;
            dly_cnt_next = 4'd1;
          end else if (rise1) begin
            perr_set     = 1'b1;
            state_next   = S_DLY1;
            dly_cnt_next = 4'd1;
          end
        end
        S_DLY2: begin
          if (!read2) begin
            perr_set     = 1'b1;
            state_next   = S_IDLE;
            dly_cnt_next = 4'd0;
          end else if (dly_cnt == DLY_END) begin
            state_next   = S_CAP2;
            dly_cnt_next = 4'd0;
          end else begin
            dly_cnt_next = dly_cnt + 4'd1;
          end
        end
        S_CAP2: begin
          hold_load = 1'b1;
          hold_in   = pixData4;
          if (room_ok) begin
            push       = 1'b1;
            push_data  = pixData3;
            state_next = S_PUSH2B;
          end else begin
            ovf_set    = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_PUSH2B: begin
          push       = 1'b1;
          push_data  = hold_byte;
          push_last  = 1'b1;
          frame_inc  = 1'b1;
          state_next = S_IDLE;
        end
        default: begin
          state_next   = S_IDLE;
          dly_cnt_next = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // Storage is not reset, so the head is masked while empty to keep the
  // outputs at zero after reset.
  assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'd0;
  assign out_last  = out_valid ? mem[rd_ptr][8]   : 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags and frame counter (a new event wins over clear)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
      frame_count  <= 8'd0;
    end else begin
      if (ovf_set)    overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;

      if (perr_set)   protocol_err <= 1'b1;
      else if (clear) protocol_err <= 1'b0;

      if (clear)          frame_count <= frame_inc ? 8'd1 : 8'd0;
      else if (frame_inc) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_readout
// Purpose  : Directed self-checking bench for pixel_readout (SAMPLE_DELAY=4,
//            DEPTH=8). A monitor records every accepted output byte; each
//            scenario compares the recorded stream and status outputs against
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_readout;

  logic       clk = 1'b0;
  logic       reset;
  logic       read1, read2;
  logic [7:0] pixData1, pixData2, pixData3, pixData4;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       clear;
  logic       overflow;
  logic       protocol_err;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  pixel_readout #(.SAMPLE_DELAY(4), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .read1        (read1),
    .read2        (read2),
    .pixData1     (pixData1),
    .pixData2     (pixData2),
    .pixData3     (pixData3),
    .pixData4     (pixData4),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .clear        (clear),
    .overflow     (overflow),
    .protocol_err (protocol_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Record every transfer away from the active edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back({out_last, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    pixData1 = a; pixData2 = b; pixData3 = c; pixData4 = d;
    read1 = 1'b1; repeat (10) tick();
    read1 = 1'b0; repeat (2)  tick();
    read2 = 1'b1; repeat (10) tick();
    read2 = 1'b0; repeat (2)  tick();
  endtask

  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b1, d});
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; read1 = 1'b0; read2 = 1'b0; clear = 1'b0; out_ready = 1'b0;
    pixData1 = 8'h00; pixData2 = 8'h00; pixData3 = 8'h00; pixData4 = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_ovf", overflow, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_fc", frame_count, 0);
    reset = 1'b0;
    tick();

    // Nominal frame
    out_ready = 1'b1;
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    repeat (3) tick();
    expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
    compare_stream("nom");
    check("nom_fc", frame_count, 1);
    check("nom_ovf", overflow, 0);
    check("nom_perr", protocol_err, 0);

    // Backpressure and overflow
    pulse_clear();
    check("clr_fc", frame_count, 0);
    out_ready = 1'b0;
    frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    check("ovf_flag", overflow, 1);
    check("ovf_fc", frame_count, 2);
    check("ovf_perr", protocol_err, 0);
    check("ovf_head", out_data, 8'hA1);
    // Head must hold steady while stalled.
    repeat (3) tick();
    check("ovf_hold", out_data, 8'hA1);
    out_ready = 1'b1;
    repeat (12) tick();
    expect_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    expect_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    compare_stream("ovf");
    check("ovf_empty", out_valid, 0);

    // Short strobe
    pulse_clear();
    check("clr_ovf", overflow, 0);
    read1 = 1'b1; repeat (2) tick();
    read1 = 1'b0; repeat (4) tick();
    check("short_perr", protocol_err, 1);
    check("short_len", got_q.size(), 0);
    frame(8'h51, 8'h52, 8'h53, 8'h54);
    repeat (3) tick();
    expect_frame(8'h51, 8'h52, 8'h53, 8'h54);
    compare_stream("short_next");

    // read2 rise while idle
    pulse_clear();
    check("clr_perr", protocol_err, 0);
    read2 = 1'b1; repeat (3) tick();
    read2 = 1'b0; repeat (2) tick();
    check("r2idle_perr", protocol_err, 1);
    check("r2idle_len", got_q.size(), 0);

    // Both strobes high during the row-1 delay
    pulse_clear();
    read1 = 1'b1; repeat (2) tick();
    read2 = 1'b1; tick();
    read1 = 1'b0; read2 = 1'b0; repeat (12) tick();
    check("both_perr", protocol_err, 1);
    check("both_len", got_q.size(), 0);
    pulse_clear();
    check("both_clr_perr", protocol_err, 0);
    check("both_clr_fc", frame_count, 0);

    // Five frames with continuous draining (pointer wrap)
    for (int f = 0; f < 5; f++) begin
      frame(8'(8'h10 * f + 1), 8'(8'h10 * f + 2), 8'(8'h10 * f + 3), 8'(8'h10 * f + 4));
      expect_frame(8'(8'h10 * f + 1), 8'(8'h10 * f + 2), 8'(8'h10 * f + 3), 8'(8'h10 * f + 4));
    end
    repeat (3) tick();
    compare_stream("wrap");
    check("wrap_fc", frame_count, 5);
    check("wrap_ovf", overflow, 0);

    // Reset during the second push of row 1
    out_ready = 1'b0;
    pixData1 = 8'h61; pixData2 = 8'h62;
    read1 = 1'b1;
    begin : wait_valid
      for (int i = 0; i < 30; i++) begin
        if (out_valid) disable wait_valid;
        tick();
      end
    end
    check("mid_wait_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_data", out_data, 0);
    check("mid_fc", frame_count, 0);
    read1 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    got_q.delete();
    frame(8'h71, 8'h72, 8'h73, 8'h74);
    repeat (3) tick();
    expect_frame(8'h71, 8'h72, 8'h73, 8'h74);
    compare_stream("after_rst");
    check("after_rst_fc", frame_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
